// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NCH AXI-stream byte sources onto one stream.
// Each grant lasts until the source's tlast or until MAXBURST beats; m_tid tags the source.
module stream_rr_arbiter #(
    parameter int NCH      = 4,
    parameter int DSIZE    = 1,
    parameter int MAXBURST = 64,
    localparam int IDW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    rst_n,
    input  logic                    iclk,
    input  logic [NCH-1:0]          s_tvalid,
    output logic [NCH-1:0]          s_tready,
    input  logic [NCH*DSIZE*8-1:0]  s_tdata,
    input  logic [NCH-1:0]          s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DSIZE*8-1:0]      m_tdata,
    output logic                    m_tlast,
    output logic [IDW-1:0]          m_tid,
    input  logic                    hold_off,
    output logic                    busy
);

    localparam int DW = DSIZE * 8;
    localparam int CW = $clog2(MAXBURST);
    localparam int SW = IDW + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]  last_gnt_q, last_gnt_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            sel_found;
    logic [IDW-1:0]  sel_idx;
    logic [SW-1:0]   cand;
    logic            burst_end;

    // Search starts just after the previous winner and wraps, giving rotating priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = SW'({1'b0, last_gnt_q}) + SW'(1) + SW'(i);
            if (cand >= SW'(NCH)) begin
                cand = cand - SW'(NCH);
            end
            if (!sel_found && s_tvalid[cand[IDW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDW-1:0];
            end
        end
    end

    assign burst_end = (beat_cnt_q == CW'(MAXBURST - 1));

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IDW'(NCH - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        s_tready   = '0;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
        m_tid      = '0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!hold_off && sel_found) begin
                    gnt_d      = sel_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy            = 1'b1;
                m_tvalid        = s_tvalid[gnt_q];
                m_tdata         = s_tdata[int'(gnt_q) * DW +: DW];
                m_tid           = gnt_q;
                m_tlast         = s_tlast[gnt_q] | burst_end;
                s_tready[gnt_q] = m_tready;
                // hold_off is deliberately ignored here; only a tlast beat ends the grant.
                if (m_tvalid && m_tready) begin
                    if (m_tlast) begin
                        last_gnt_d = gnt_q;
                        beat_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (NCH=4, DSIZE=1, MAXBURST=64).
// Sources are simple counters: data = {ch, count[5:0]}, tlast every plen[ch] beats.
module tb_stream_rr_arbiter;

    localparam int NCH = 4;

    logic             rst_n;
    logic             iclk;
    logic [NCH-1:0]   s_tvalid;
    logic [NCH-1:0]   s_tready;
    logic [NCH*8-1:0] s_tdata;
    logic [NCH-1:0]   s_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [7:0]       m_tdata;
    logic             m_tlast;
    logic [1:0]       m_tid;
    logic             hold_off;
    logic             busy;

    logic [NCH-1:0]   src_en;
    int               src_cnt [NCH];
    int               plen    [NCH];
    int               checks;
    int               errors;

    stream_rr_arbiter #(.NCH(NCH), .DSIZE(1), .MAXBURST(64)) dut (
        .rst_n    (rst_n),
        .iclk     (iclk),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .hold_off (hold_off),
        .busy     (busy)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    assign s_tvalid = src_en;

    always_comb begin
        s_tdata = '0;
        s_tlast = '0;
        for (int k = 0; k < NCH; k++) begin
            s_tdata[k*8 +: 8] = 8'((k << 6) | (src_cnt[k] & 63));
            s_tlast[k]        = ((src_cnt[k] % plen[k]) == plen[k] - 1);
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic       hold;
        logic       exp_mvalid;
        logic [1:0] exp_tid;
        logic       exp_last;
        logic [3:0] exp_sready;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Close the current cycle: record handshakes, cross the edge, advance sources.
    task automatic cycle_end();
        logic [NCH-1:0] f;
        f = s_tvalid & s_tready;
        @(posedge iclk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (f[k]) src_cnt[k] = src_cnt[k] + 1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        src_en   = '0;
        m_tready = 1'b1;
        hold_off = 1'b0;
        for (int k = 0; k < NCH; k++) src_cnt[k] = 0;
        repeat (2) @(posedge iclk);
        #1;
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_tid",    32'(m_tid),    32'd0);
        chk("rst_tlast",  32'(m_tlast),  32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        m_tready = 1'b1;
        hold_off = 1'b0;
        src_en   = '0;
        for (int k = 0; k < NCH; k++) begin
            src_cnt[k] = 0;
            plen[k]    = 3;
        end

        // Round robin, all valid, 3-beat packets: period of 4 cycles (bubble + 3 beats).
        for (int c = 0; c < 20; c++) begin
            int pos;
            int g;
            pos = c % 4;
            g   = c / 4;
            vecs[c].valid      = 4'hF;
            vecs[c].ready      = 1'b1;
            vecs[c].hold       = 1'b0;
            vecs[c].exp_mvalid = (pos != 0);
            vecs[c].exp_tid    = (pos != 0) ? 2'(g % 4) : 2'd0;
            vecs[c].exp_last   = (pos == 3);
            vecs[c].exp_sready = (pos != 0) ? 4'(1 << (g % 4)) : 4'd0;
            vecs[c].exp_data   = 8'(((g % 4) << 6) | ((g / 4) * 3 + pos - 1));
        end

        do_reset();
        for (int c = 0; c < 20; c++) begin
            src_en   = vecs[c].valid;
            m_tready = vecs[c].ready;
            hold_off = vecs[c].hold;
            @(negedge iclk);
            chk("rr_mvalid", 32'(m_tvalid), 32'(vecs[c].exp_mvalid));
            chk("rr_sready", 32'(s_tready), 32'(vecs[c].exp_sready));
            if (vecs[c].exp_mvalid) begin
                chk("rr_tid",   32'(m_tid),   32'(vecs[c].exp_tid));
                chk("rr_tlast", 32'(m_tlast), 32'(vecs[c].exp_last));
                chk("rr_data",  32'(m_tdata), 32'(vecs[c].exp_data));
                if (m_tlast) $display("grant done ch=%0d cycle=%0d", m_tid, c);
            end
            cycle_end();
        end

        // Channel 2 alone, one 100-beat packet: cut at 64 then 36 beats, same id.
        begin
            int beats;
            int grants;
            int nexp;
            int glen [2];
            beats   = 0;
            grants  = 0;
            nexp    = 0;
            glen[0] = 0;
            glen[1] = 0;
            do_reset();
            plen[2] = 100;
            src_en  = 4'b0100;
            for (int c = 0; c < 200 && grants < 2; c++) begin
                @(negedge iclk);
                if (m_tvalid && m_tready) begin
                    chk("burst_tid",  32'(m_tid),   32'd2);
                    chk("burst_data", 32'(m_tdata), 32'(8'h80 | (nexp & 63)));
                    beats++;
                    nexp++;
                    if (m_tlast) begin
                        glen[grants] = beats;
                        $display("grant done ch=%0d beats=%0d", m_tid, beats);
                        grants++;
                        beats = 0;
                    end
                end
                cycle_end();
            end
            chk("burst_grants", 32'(grants),  32'd2);
            chk("burst_len0",   32'(glen[0]), 32'd64);
            chk("burst_len1",   32'(glen[1]), 32'd36);
            plen[2] = 3;
        end

        // hold_off blocks new grants; released it grants ch1 next cycle, then ch3.
        begin
            logic       ev [6];
            logic [1:0] et [6];
            logic       el [6];
            ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            et = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3};
            el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            do_reset();
            for (int k = 0; k < NCH; k++) plen[k] = 2;
            src_en   = 4'b1010;
            hold_off = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge iclk);
                chk("hold_mvalid", 32'(m_tvalid), 32'd0);
                chk("hold_busy",   32'(busy),     32'd0);
                cycle_end();
            end
            hold_off = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge iclk);
                chk("hold_rel_mvalid", 32'(m_tvalid), 32'(ev[c]));
                if (ev[c]) begin
                    chk("hold_rel_tid",   32'(m_tid),   32'(et[c]));
                    chk("hold_rel_tlast", 32'(m_tlast), 32'(el[c]));
                end
                cycle_end();
            end
        end

        // Channel 0, 10-beat packet, m_tready toggling: data in order, no loss or duplicate.
        begin
            int  got;
            bit  done;
            got  = 0;
            done = 1'b0;
            do_reset();
            plen[0] = 10;
            src_en  = 4'b0001;
            for (int c = 0; c < 60 && !done; c++) begin
                m_tready = 1'(c & 1);
                @(negedge iclk);
                chk("tog_sready_others", 32'(s_tready & 4'hE), 32'd0);
                if (m_tvalid && m_tready) begin
                    chk("tog_data", 32'(m_tdata), 32'(got));
                    got++;
                    if (m_tlast) done = 1'b1;
                end
                cycle_end();
            end
            $display("grant done ch=0 beats=%0d (toggled ready)", got);
            chk("tog_done",  32'(done), 32'd1);
            chk("tog_count", 32'(got),  32'd10);
            m_tready = 1'b1;
        end

        // Async reset on beat 5 of a channel-1 grant; afterwards channel 0 wins first.
        begin
            bit found;
            found = 1'b0;
            do_reset();
            plen[1] = 8;
            src_en  = 4'b0010;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge iclk);
                if (m_tvalid && m_tready && m_tdata == 8'h44) found = 1'b1;
                else cycle_end();
            end
            chk("arst_reach", 32'(found), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_mvalid", 32'(m_tvalid), 32'd0);
            chk("arst_sready", 32'(s_tready), 32'd0);
            chk("arst_busy",   32'(busy),     32'd0);
            chk("arst_tid",    32'(m_tid),    32'd0);
            for (int k = 0; k < NCH; k++) src_cnt[k] = 0;
            src_en = 4'b0011;
            @(posedge iclk);
            #1;
            rst_n = 1'b1;
            @(negedge iclk);
            chk("arst_idle_mvalid", 32'(m_tvalid), 32'd0);
            cycle_end();
            @(negedge iclk);
            chk("arst_first_mvalid", 32'(m_tvalid), 32'd1);
            chk("arst_first_tid",    32'(m_tid),    32'd0);
            cycle_end();
        end

        // Channel 0 stalls 4 cycles mid-packet (hold_off raised meanwhile): grant kept.
        begin
            do_reset();
            for (int k = 0; k < NCH; k++) plen[k] = 6;
            src_en = 4'b0111;
            @(negedge iclk);
            chk("stall_idle", 32'(m_tvalid), 32'd0);
            cycle_end();
            for (int i = 0; i < 2; i++) begin
                @(negedge iclk);
                chk("stall_pre_tid",  32'(m_tid),   32'd0);
                chk("stall_pre_data", 32'(m_tdata), 32'(i));
                cycle_end();
            end
            src_en[0] = 1'b0;
            hold_off  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge iclk);
                chk("stall_busy",   32'(busy),              32'd1);
                chk("stall_mvalid", 32'(m_tvalid),          32'd0);
                chk("stall_tid",    32'(m_tid),             32'd0);
                chk("stall_others", 32'(s_tready & 4'hE),   32'd0);
                cycle_end();
            end
            src_en[0] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge iclk);
                chk("stall_post_mvalid", 32'(m_tvalid), 32'd1);
                chk("stall_post_tid",    32'(m_tid),    32'd0);
                chk("stall_post_data",   32'(m_tdata),  32'(2 + i));
                chk("stall_post_tlast",  32'(m_tlast),  32'(i == 3));
                cycle_end();
            end
            $display("grant done ch=0 beats=6 (stalled)");
            for (int i = 0; i < 2; i++) begin
                @(negedge iclk);
                chk("stall_hold_busy", 32'(busy), 32'd0);
                cycle_end();
            end
            hold_off = 1'b0;
            @(negedge iclk);
            chk("stall_rel_idle", 32'(m_tvalid), 32'd0);
            cycle_end();
            @(negedge iclk);
            chk("stall_next_mvalid", 32'(m_tvalid), 32'd1);
            chk("stall_next_tid",    32'(m_tid),    32'd1);
            cycle_end();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
